// File: rtl/recfn_pkg.sv
// recfn_pkg: shared widths, constants, FCLASS bit positions and the unpacked
// recoded-float record used by recoded-binary64 consumers.
// No ports (package).
package recfn_pkg;

  localparam int EXP_W         = 11;
  localparam int SIG_W         = 53;
  localparam int RECFN_W       = 65;
  localparam int FN_W          = 64;
  localparam int CLASS_W       = 10;
  localparam int MIN_NORM_SEXP = 1026;
  localparam int EXP_BIAS_ADJ  = 1025;

  localparam logic [FN_W-1:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

  // FCLASS mask bit positions (RISC-V ordering)
  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  // Decoded recoded value; sig = {1'b0, hidden bit, fraction}
  typedef struct packed {
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;
    logic               sign;
    logic [EXP_W+1:0]   s_exp;
    logic [SIG_W:0]     sig;
  } raw_fn_t;

endpackage

// File: rtl/recfn_unpack.sv
// recfn_unpack: combinational decode of a 65-bit recoded binary64 into a
// raw_fn_t record, plus the subnormal flag and the denormalisation shift
// needed to rebuild an IEEE subnormal fraction.
// Ports:
//   recfn   in  65  recoded operand {sign, exp[11:0], fract[51:0]}
//   raw     out     decoded flags, sign, zero-extended exponent, significand
//   is_sub  out 1   exponent below the smallest normal (also true for zero)
//   sh_dist out 6   extra right shift applied after dropping the low sig bit
module recfn_unpack
  import recfn_pkg::*;
(
  input  logic [RECFN_W-1:0] recfn,
  output raw_fn_t            raw,
  output logic               is_sub,
  output logic [5:0]         sh_dist
);

  logic [11:0] exp_rec;
  logic        is_special;
  logic        is_zero;

  assign exp_rec    = recfn[63:52];
  assign is_zero    = (exp_rec[11:9] == 3'b000);
  assign is_special = (exp_rec[11:10] == 2'b11);

  always_comb begin
    raw         = '0;
    raw.sign    = recfn[64];
    raw.is_zero = is_zero;
    raw.is_inf  = is_special & ~exp_rec[9];
    raw.is_nan  = is_special & exp_rec[9];
    raw.s_exp   = {1'b0, exp_rec};
    raw.sig     = {1'b0, ~is_zero, recfn[51:0]};
  end

  assign is_sub = ({1'b0, exp_rec} < 13'(MIN_NORM_SEXP));

  // Only meaningful for subnormal exponents 974..1025, where it yields 0..51
  assign sh_dist = 6'd1 - exp_rec[5:0];

endmodule

// File: rtl/recfn_to_fn_pipe.sv
// recfn_to_fn_pipe: two-stage pipelined recoded-binary64 -> IEEE binary64
// converter with RISC-V FCLASS mask and a pass-through tag. Stage 1 registers
// the decoded operand, stage 2 registers the packed result. valid/ready on
// both sides with full backpressure; 2-cycle latency, 1 result/cycle.
// Optional build macro: RECFN_TO_FN_CANON_NAN_EN replaces every NaN result
// with the canonical quiet NaN (class mask still reports the input NaN kind).
// Ports:
//   clock, reset (sync, active-high)
//   io_in_valid/io_in_ready, io_in_bits_recfn[64:0], io_in_bits_tag[TAG_W-1:0]
//   io_out_valid/io_out_ready, io_out_bits_fn[63:0], io_out_bits_class[9:0],
//   io_out_bits_tag[TAG_W-1:0]
module recfn_to_fn_pipe
  import recfn_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [RECFN_W-1:0]   io_in_bits_recfn,
  input  logic [TAG_W-1:0]     io_in_bits_tag,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [FN_W-1:0]      io_out_bits_fn,
  output logic [CLASS_W-1:0]   io_out_bits_class,
  output logic [TAG_W-1:0]     io_out_bits_tag
);

  raw_fn_t          dec_raw;
  logic             dec_is_sub;
  logic [5:0]       dec_sh_dist;

  recfn_unpack u_unpack (
    .recfn   (io_in_bits_recfn),
    .raw     (dec_raw),
    .is_sub  (dec_is_sub),
    .sh_dist (dec_sh_dist)
  );

  logic             s1_valid;
  raw_fn_t          s1_raw;
  logic             s1_is_sub;
  logic [5:0]       s1_sh_dist;
  logic [TAG_W-1:0] s1_tag;

  logic               s2_valid;
  logic [FN_W-1:0]    s2_fn;
  logic [CLASS_W-1:0] s2_class;
  logic [TAG_W-1:0]   s2_tag;

  logic s2_adv;
  logic in_fire;
  logic s1_move;

  assign s2_adv      = !s2_valid || io_out_ready;
  assign io_in_ready = !s1_valid || s2_adv;
  assign in_fire     = io_in_valid && io_in_ready;
  assign s1_move     = s1_valid && s2_adv;

  // Stage 2 pack logic, fed from the stage-1 registers
  logic               s1_is_special;
  logic [51:0]        denorm_fract;
  logic [EXP_W-1:0]   exp_out;
  logic [51:0]        fract_out;
  logic [FN_W-1:0]    pack_fn;
  logic [CLASS_W-1:0] pack_class;

  assign s1_is_special = s1_raw.is_nan | s1_raw.is_inf;
  assign denorm_fract  = 52'(s1_raw.sig[SIG_W:1] >> s1_sh_dist);

  always_comb begin
    if (s1_is_sub)
      exp_out = '0;
    else if (s1_is_special)
      exp_out = 11'h7FF;
    else
      // 13-bit subtract truncated to 11 bits == exp[10:0] - 1025 mod 2^11
      exp_out = 11'(s1_raw.s_exp - 13'(EXP_BIAS_ADJ));

    if (s1_is_sub)
      fract_out = denorm_fract;
    else if (s1_raw.is_inf)
      fract_out = '0;
    else
      fract_out = s1_raw.sig[51:0];

    pack_fn = {s1_raw.sign, exp_out, fract_out};
`ifdef RECFN_TO_FN_CANON_NAN_EN
    if (s1_raw.is_nan)
      pack_fn = CANON_NAN_D;
`endif

    // Zero is checked before subnormal since zero exponents also set is_sub
    pack_class = '0;
    if (s1_raw.is_nan) begin
      if (s1_raw.sig[51]) pack_class[CLS_QNAN] = 1'b1;
      else                pack_class[CLS_SNAN] = 1'b1;
    end else if (s1_raw.is_inf) begin
      if (s1_raw.sign) pack_class[CLS_NEG_INF] = 1'b1;
      else             pack_class[CLS_POS_INF] = 1'b1;
    end else if (s1_raw.is_zero) begin
      if (s1_raw.sign) pack_class[CLS_NEG_ZERO] = 1'b1;
      else             pack_class[CLS_POS_ZERO] = 1'b1;
    end else if (s1_is_sub) begin
      if (s1_raw.sign) pack_class[CLS_NEG_SUB] = 1'b1;
      else             pack_class[CLS_POS_SUB] = 1'b1;
    end else begin
      if (s1_raw.sign) pack_class[CLS_NEG_NORM] = 1'b1;
      else             pack_class[CLS_POS_NORM] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (io_in_ready) s1_valid <= io_in_valid;
      if (s2_adv)      s2_valid <= s1_valid;
    end
  end

  // Data registers carry no reset; they are qualified by the valids
  always_ff @(posedge clock) begin
    if (in_fire) begin
      s1_raw     <= dec_raw;
      s1_is_sub  <= dec_is_sub;
      s1_sh_dist <= dec_sh_dist;
      s1_tag     <= io_in_bits_tag;
    end
    if (s1_move) begin
      s2_fn    <= pack_fn;
      s2_class <= pack_class;
      s2_tag   <= s1_tag;
    end
  end

  assign io_out_valid      = s2_valid;
  assign io_out_bits_fn    = s2_fn;
  assign io_out_bits_class = s2_class;
  assign io_out_bits_tag   = s2_tag;

endmodule

// File: doc/recfn_to_fn_pipe.md
Name: recfn_to_fn_pipe

Overview:
- Two-stage pipelined converter from recoded binary64 (65-bit recFN: sign, 12-bit exp, 52-bit fract) to IEEE binary64.
- Also produces a RISC-V FCLASS mask. It is the inverse of the raw-to-recoded rounding path and sits on the FPU writeback/FMV/FSD path.
- Uses a valid/ready handshake with full backpressure and an opaque tag carried alongside each result.

Parameters:
- TAG_W, 5, width of the opaque tag passed through with each conversion.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_in_valid  in  1  input beat valid
- io_in_ready  out  1  converter accepts input
- io_in_bits_recfn  in  65  recoded binary64 operand
- io_in_bits_tag  in  TAG_W  opaque tag
- io_out_valid  out  1  result valid
- io_out_ready  in  1  consumer accepts result
- io_out_bits_fn  out  64  IEEE binary64 result
- io_out_bits_class  out  10  one-hot FCLASS mask
- io_out_bits_tag  out  TAG_W  tag of this result

Behaviour:
- Clock and reset are decided: one clock (clock); reset is synchronous and active-high (reset).
- Reset: both stage valids clear, so io_out_valid=0. Data regs are don't-care. io_in_ready=1 from the first cycle after reset.
- A reset asserted mid-operation drops all in-flight beats; no output is produced for them.
- Handshake:
  - Transfer occurs when valid&ready.
  - io_out_bits_* stay stable while io_out_valid&&!io_out_ready.
  - io_in_ready = !s1_valid || s2_adv, where s2_adv = !s2_valid || io_out_ready. Readiness is combinational from io_out_ready.
  - Full throughput (1/cycle) when unstalled. Latency is 2 cycles: accept at cycle N, io_out_valid at N+2.
  - Order preserved, no drops, no duplicates. With s1 and s2 both full, at most 2 beats are held.
- Stage 1 (decode), registered on accept:
  - exp=recfn[63:52]; isZero=exp[11:9]==0; isSpecial=exp[11:10]==2'b11; isInf=isSpecial&!exp[9]; isNaN=isSpecial&exp[9].
  - sExp=13-bit zero-extended exp; sig={1'b0,!isZero,fract} (54b).
  - isSub = sExp<1026.
  - shDist = (1 - sExp[5:0]) mod 64.
  - Register sign, class flags, sig, shDist, exp[10:0], tag.
- Stage 2 (pack):
  - denormFract = ((sig>>1)>>shDist)[51:0].
  - expOut = isSub ? 0 : isSpecial ? 11'h7FF : exp[10:0]-11'd1025 (mod 2^11).
  - fractOut = isSub ? denormFract : isInf ? 0 : fract (NaN payload preserved).
  - fn = {sign, expOut, fractOut}.
- class bits:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN (NaN & !fract[51]), 9 qNaN (NaN & fract[51]).
  - Exactly one bit is set.
  - Zero takes precedence over subnormal (isSub is true for zero exponents).
- No exception flags: conversion is exact.

Optional Feature:
- RECFN_TO_FN_CANON_NAN_EN defined: any NaN output is replaced by 64'h7FF8000000000000. The class mask still reports sNaN/qNaN from the input.
- Undefined: sign and payload pass through unchanged.

Decomposition:
- Package recfn_pkg holds:
  - localparams EXP_W=11, SIG_W=53, RECFN_W=65, FN_W=64, MIN_NORM_SEXP=1026, EXP_BIAS_ADJ=1025, CANON_NAN_D.
  - Enum/consts for the FCLASS bit positions.
  - typedef raw_fn_t {isNaN, isInf, isZero, sign, sExp[12:0], sig[53:0]}, which is also the stage-1 register payload.
- Sub-module recfn_unpack: combinational recFN -> raw_fn_t plus isSub and shDist. It is reusable by other recoded-format consumers.

Test Plan:
- Normal: in 65'h0_8000000000000000 (+1.0), tag 3, out_ready=1 -> two cycles later fn=64'h3FF0000000000000, class=10'h040, tag=3.
- Subnormal: in 65'h0_3CE0000000000000 -> fn=64'h0000000000000001, class=10'h020. Also -0: in 65'h1_0000000000000000 -> fn=64'h8000000000000000, class=10'h008.
- Specials:
  - -inf in 65'h1_C000000000000000 -> fn=64'hFFF0000000000000, class=10'h001.
  - qNaN in 65'h0_E008000000000001 -> fn=64'h7FF8000000000001 (macro off) or 64'h7FF8000000000000 (on), class=10'h200.
  - sNaN in 65'h0_E000000000000001 -> class=10'h100.
- Backpressure: stream 4 beats (tags 0..3) with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, out_bits stable. On release, tags arrive 0,1,2,3 at one per cycle with no loss.
- Reset mid-flight: 2 beats in pipeline, pulse reset 1 cycle -> out_valid=0 next cycle, no stale beat emitted, in_ready=1 afterwards.
- Throughput: 100 random back-to-back ops with out_ready=1 -> one result per cycle after 2-cycle latency. Each result matches a software binary64 reference model, including every exponent around 1025/1026.
